// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte requesters, with a per-frame watchdog.
// Latency: req seen in IDLE at cycle T -> ack/tx_start at T+1; tx_done_tick at D -> done at D+1, next tx_start at D+2.
// Backpressure: a requester holds req and its byte until ack; only one frame is in flight, so others wait.
module uart_tx_arbiter #(
    parameter int DBIT     = 8,
    parameter int NREQ     = 4,
    parameter int MAX_WAIT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] din,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int PW = $clog2(NREQ);
    localparam int WW = $clog2(MAX_WAIT);
    localparam logic [NREQ-1:0] ONE    = NREQ'(1);
    localparam logic [WW-1:0]   EXPIRE = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  grant;
    logic [WW-1:0]  wd;
    logic [WW-1:0]  wd_inc;
    logic [PW-1:0]  win_idx;
    logic           win_vld;

    // Round-robin pick: first asserted req at ptr+1, ptr+2, ... ptr+NREQ (mod NREQ).
    // Scanning from the far end down lets the nearest candidate overwrite the others.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                win_idx = PW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    // Saturating watchdog increment; the frame expires on the cycle the count would reach MAX_WAIT-1,
    // which puts the sticky error flag up exactly MAX_WAIT cycles after tx_start.
    always_comb begin
        wd_inc = (wd == '1) ? wd : wd + 1'b1;
    end

    // Arbitration/launch/wait FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= PW'(NREQ - 1);
            grant       <= '0;
            wd          <= '0;
            tx_din      <= '0;
            ack         <= '0;
            done        <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack      <= '0;
            done     <= '0;
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant    <= win_idx;
                        tx_din   <= din[win_idx*DBIT +: DBIT];
                        ack      <= ONE << win_idx;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // The byte is already latched; req is not re-examined here.
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        // Completion beats a simultaneous watchdog expiry.
                        done  <= ONE << grant;
                        ptr   <= grant;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wd_inc == EXPIRE) begin
                        wd          <= wd_inc;
                        timeout_err <= 1'b1;
                        ptr         <= grant;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, DBIT=8, MAX_WAIT=64).
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpressure: a hand-driven transmitter model raises tx_done_tick at fixed offsets from tx_start.
module tb_uart_tx_arbiter;

    localparam int DBIT     = 8;
    localparam int NREQ     = 4;
    localparam int MAX_WAIT = 64;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] din;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      done;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_din;
    logic                 tx_done_tick;
    logic                 busy;
    logic                 timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ack1_cnt = 0;
    int done_cnt = 0;

    uart_tx_arbiter #(
        .DBIT     (DBIT),
        .NREQ     (NREQ),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .din          (din),
        .ack          (ack),
        .done         (done),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running tallies of ack[1] and done pulses, used to prove absence of a pulse over a window.
    always @(negedge clk) begin
        if (ack[1]) ack1_cnt = ack1_cnt + 1;
        if (done != '0) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait on falling edges until tx_start is seen; n is the number of edges waited, -1 on budget expiry.
    task automatic wait_start(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < budget);
        if (!tx_start) n = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        req          = '0;
        tx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int snap;
        reset        = 1'b1;
        req          = '0;
        din          = '0;
        tx_done_tick = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ack",      ack,         0);
        check("rst_done",     done,        0);
        check("rst_tx_start", tx_start,    0);
        check("rst_tx_din",   tx_din,      0);
        check("rst_busy",     busy,        0);
        check("rst_timeout",  timeout_err, 0);
        reset = 1'b0;

        // Single requester, transmitter completes 50 cycles after start
        @(negedge clk);
        req = 4'b0100;
        din = 32'h00A5_0000;
        wait_start(8, n);
        check("single_latency", n, 1);
        check("single_ack",     ack,    4'b0100);
        check("single_tx_din",  tx_din, 8'hA5);
        check("single_busy",    busy,   1);
        req = '0;
        @(negedge clk);
        check("single_ack_pulse",   ack,      0);
        check("single_start_pulse", tx_start, 0);
        check("single_busy_wait",   busy,     1);
        repeat (49) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        check("single_done", done, 4'b0100);
        check("single_idle", busy, 0);
        @(negedge clk);
        check("single_done_pulse", done,     0);
        check("single_no_restart", tx_start, 0);

        // Fairness: all four request continuously, grant order 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        din = 32'h4332_2110;
        for (int i = 0; i < 5; i++) begin
            wait_start(8, n);
            check("fair_gap",    n,      1);
            check("fair_ack",    ack,    32'(1) << (i % 4));
            check("fair_tx_din", tx_din, 32'h10 + 32'h11 * (i % 4));
            @(negedge clk);
            check("fair_ack_pulse", ack, 0);
            repeat (19) @(negedge clk);
            tx_done_tick = 1'b1;
            @(negedge clk);
            tx_done_tick = 1'b0;
            check("fair_done", done, 32'(1) << (i % 4));
        end

        // Withdrawal: requester 1 pulses req during WAIT and must never be served
        do_reset();
        snap = ack1_cnt;
        req  = 4'b0001;
        din  = 32'h0000_0055;
        wait_start(8, n);
        check("wd_ack0", ack, 4'b0001);
        req = 4'b1000;
        din[24 +: 8] = 8'hBB;
        @(negedge clk);
        @(negedge clk);
        req[1] = 1'b1;
        din[8 +: 8] = 8'h66;
        @(negedge clk);
        req[1] = 1'b0;
        repeat (7) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        check("wd_done0", done, 4'b0001);
        wait_start(8, n);
        check("wd_gap",     n,      1);
        check("wd_ack3",    ack,    4'b1000);
        check("wd_tx_din3", tx_din, 8'hBB);
        check("wd_no_ack1", ack1_cnt - snap, 0);

        // Coincidence: tx_done_tick on the watchdog expiry cycle
        do_reset();
        req = 4'b0010;
        din = 32'h0000_C300;
        wait_start(8, n);
        check("coin_ack", ack, 4'b0010);
        req = '0;
        repeat (63) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        check("coin_done",    done,        4'b0010);
        check("coin_timeout", timeout_err, 0);
        check("coin_idle",    busy,        0);

        // Timeout: no completion; flag at exactly MAX_WAIT cycles after tx_start, then next requester served
        req = 4'b0101;
        din = 32'h0099_0077;
        wait_start(8, n);
        check("to_ack2",    ack,    4'b0100);
        check("to_tx_din2", tx_din, 8'h99);
        req  = 4'b0001;
        snap = done_cnt;
        repeat (63) @(negedge clk);
        check("to_before_expiry", timeout_err, 0);
        check("to_busy_before",   busy,        1);
        @(negedge clk);
        check("to_expiry",  timeout_err, 1);
        check("to_idle",    busy,        0);
        check("to_no_done", done_cnt - snap, 0);
        wait_start(8, n);
        check("to_next_gap",    n,      1);
        check("to_next_ack0",   ack,    4'b0001);
        check("to_next_tx_din", tx_din, 8'h77);
        req = '0;
        repeat (5) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        check("to_next_done", done,        4'b0001);
        check("to_sticky",    timeout_err, 1);

        // Reset mid-WAIT: outputs drop asynchronously, stray tick ignored, requester 0 wins next
        req = 4'b0010;
        din = 32'h0000_E100;
        wait_start(8, n);
        check("mr_ack1",   ack,    4'b0010);
        check("mr_tx_din", tx_din, 8'hE1);
        req = '0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mr_async_busy",    busy,        0);
        check("mr_async_timeout", timeout_err, 0);
        check("mr_async_tx_din",  tx_din,      0);
        check("mr_async_ack",     ack,         0);
        check("mr_async_start",   tx_start,    0);
        @(negedge clk);
        reset = 1'b0;
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        check("mr_stray_done",  done,     0);
        check("mr_stray_busy",  busy,     0);
        check("mr_stray_start", tx_start, 0);
        req = 4'b1111;
        din = 32'h4332_2110;
        wait_start(8, n);
        check("mr_next_latency", n,      1);
        check("mr_next_ack0",    ack,    4'b0001);
        check("mr_next_tx_din",  tx_din, 8'h10);
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter between NREQ byte requesters.
- Accepts a byte from the winning requester, launches the transmitter, and waits for the transmitter's completion tick.
- Supervises each frame with a watchdog.
- Sits between client logic (command responder, status reporter, loopback echo) and the single TX serializer driven by the 16x baud tick.

Parameters:
- DBIT, 8: data bits per frame; width of each requester byte and of tx_din.
- NREQ, 4: number of requesters, minimum 2.
- MAX_WAIT, 4096: clk cycles allowed between tx_start and tx_done_tick before the frame is abandoned.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; held high with stable data until ack.
- din  input  NREQ*DBIT  requester bytes; requester i occupies bits [i*DBIT +: DBIT].
- ack  output  NREQ  one-cycle pulse: requester's byte has been taken.
- done  output  NREQ  one-cycle pulse: requester's frame has finished transmitting.
- tx_start  output  1  one-cycle pulse to the transmitter.
- tx_din  output  DBIT  byte to the transmitter; stable from tx_start until the frame ends.
- tx_done_tick  input  1  one-cycle completion pulse from the transmitter.
- busy  output  1  high in LAUNCH and WAIT.
- timeout_err  output  1  sticky flag; set on watchdog expiry.

Behaviour:
- Reset values: all outputs 0; state=IDLE; ptr=NREQ-1 (requester 0 wins first); watchdog counter=0; granted index=0.
- All outputs are registered.
- IDLE:
  - If req is nonzero, the winner is the first asserted req scanning ptr+1, ptr+2, …, ptr+NREQ, modulo NREQ.
  - Latch the winner index into the granted index and latch din[winner] into tx_din.
  - Go to LAUNCH.
  - If req is zero, stay in IDLE.
- LAUNCH (exactly one cycle):
  - tx_start=1 and ack[grant]=1.
  - Clear the watchdog and go to WAIT.
  - Latency: req rising in IDLE at cycle T gives tx_start and ack at cycle T+1.
- WAIT:
  - The watchdog increments every cycle.
  - On tx_done_tick: done[grant]=1 in the next cycle, ptr=grant, go to IDLE.
  - On watchdog reaching MAX_WAIT-1 without tx_done_tick: timeout_err=1 (sticky until reset), ptr=grant, go to IDLE, no done pulse.
  - If tx_done_tick coincides with watchdog expiry, completion wins: done pulses and timeout_err is unchanged.
- tx_done_tick in IDLE or LAUNCH is ignored.
- Exactly one ack bit and one done bit may be high in any cycle.
- ack and tx_start are always coincident.
- Requester rules:
  - A requester may drop req before its ack; it then loses the grant with no side effects.
  - req dropped after selection, during LAUNCH, is not re-checked: the latched byte is still sent.
  - A requester may re-assert req in the cycle after its ack. It is then queued behind the other active requesters.
- Back-to-back: done pulses in the same cycle the FSM is in IDLE. That IDLE cycle arbitrates, so the minimum gap from tx_done_tick to the next tx_start is 2 cycles.
- The watchdog counter is $clog2(MAX_WAIT) bits wide and saturates; it never wraps.
- Asynchronous reset mid-frame:
  - Immediately returns to IDLE and drops tx_start, ack and done.
  - Clears timeout_err.
  - Restores ptr=NREQ-1.
  - The transmitter is not notified; its later tx_done_tick is ignored in IDLE.

Test Plan:
- Single requester: req=4'b0100 with din[2]=8'hA5 → ack=4'b0100 and tx_start one cycle later with tx_din=8'hA5; tx_done_tick after 50 cycles → done=4'b0100 next cycle, busy=0.
- Fairness: req=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43; transmitter model asserts done 20 cycles after start → grant order 0,1,2,3,0, each ack a single pulse, 2-cycle gap between done and the next tx_start.
- Withdrawal: req[1] high for one cycle while frame 0 is in WAIT, then low → requester 1 never acked; next grant goes to the next active requester.
- Timeout: MAX_WAIT=64, transmitter model never ticks → timeout_err=1 at 64 cycles after tx_start, no done pulse, FSM returns to IDLE and serves the next requester; timeout_err stays high.
- Coincidence: tx_done_tick on the exact expiry cycle → done pulses, timeout_err stays 0.
- Reset mid-WAIT: reset pulsed 10 cycles after tx_start → all outputs 0 asynchronously; stray tx_done_tick after release is ignored; next grant is requester 0.
